// File: rtl/nmr_bstrm_pkg.sv
// Shared definitions for the NMR bitstream FIFO producer.
// Contents: field widths, MORE-bit position, maximum chunk length,
// terminal (abort) word, FSM state encoding and a word-packing helper.
package nmr_bstrm_pkg;

   localparam int BUS_WIDTH = 32;
   localparam int PAT_WIDTH = 7;
   localparam int CNT_WIDTH = 24;
   localparam int DUR_WIDTH = 32;
   localparam int MORE_BIT  = BUS_WIDTH - 1;

   // Largest hold one word can express: count field all-ones means 2^CNT_WIDTH cycles.
   localparam logic [DUR_WIDTH-1:0] CHUNK_LEN = DUR_WIDTH'(1) << CNT_WIDTH;

   // Written on abort: MORE=0 so the player ends, pattern 0, count 0.
   localparam logic [BUS_WIDTH-1:0] TERM_WORD = '0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_EMIT,
      ST_ABORT,
      ST_FIN
   } state_t;

   function automatic logic [BUS_WIDTH-1:0] pack_word(
      input logic                 more,
      input logic [PAT_WIDTH-1:0] pat,
      input logic [CNT_WIDTH-1:0] cnt
   );
      return {more, pat, cnt};
   endfunction

endpackage

// File: rtl/nmr_bstrm_fifo_wr_if.sv
// Bus interfaces of the bitstream FIFO producer.
//  nmr_bstrm_entry_if : loader -> producer entry handshake
//     valid, ready, pattern[PAT_WIDTH], dur[DUR_WIDTH], last
//  nmr_bstrm_fifo_if  : producer -> FIFO write port
//     wrreq, data[BUS_WIDTH], full
// master drives the transfer, slave receives it.
interface nmr_bstrm_entry_if;
   import nmr_bstrm_pkg::*;

   logic                 valid;
   logic                 ready;
   logic [PAT_WIDTH-1:0] pattern;
   logic [DUR_WIDTH-1:0] dur;
   logic                 last;

   modport master (output valid, pattern, dur, last, input  ready);
   modport slave  (input  valid, pattern, dur, last, output ready);
endinterface

interface nmr_bstrm_fifo_if;
   import nmr_bstrm_pkg::*;

   logic                 wrreq;
   logic [BUS_WIDTH-1:0] data;
   logic                 full;

   modport master (output wrreq, data, input  full);
   modport slave  (input  wrreq, data, output full);
endinterface

// File: rtl/nmr_bstrm_dur_split.sv
// Remaining-duration tracker. Holds the cycles still to be emitted for the
// current entry and splits them into word-sized chunks.
//  CLK, RST : clock, asynchronous active-high reset
//  load_i   : load dur_i as the new remaining duration
//  dur_i    : entry duration
//  step_i   : current chunk was written; advance to the next one
//  chunk_o  : count field for the current word (hold = count+1 cycles)
//  final_o  : current chunk is the last one for this entry
module nmr_bstrm_dur_split
   import nmr_bstrm_pkg::*;
(
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 load_i,
   input  logic [DUR_WIDTH-1:0] dur_i,
   input  logic                 step_i,
   output logic [CNT_WIDTH-1:0] chunk_o,
   output logic                 final_o
);

   logic [DUR_WIDTH-1:0] remaining_q;
   logic [DUR_WIDTH-1:0] remaining_d;

   assign final_o = (remaining_q <= CHUNK_LEN);
   // For remaining == 2^CNT_WIDTH the low bits are zero and the decrement
   // wraps to all-ones, which is exactly the full-chunk count.
   assign chunk_o = final_o ? (remaining_q[CNT_WIDTH-1:0] - CNT_WIDTH'(1)) : '1;

   always_comb begin
      remaining_d = remaining_q;
      if (load_i)
         remaining_d = dur_i;
      else if (step_i && !final_o)
         remaining_d = remaining_q - CHUNK_LEN;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         remaining_q <= '0;
      else
         remaining_q <= remaining_d;
   end

endmodule

// File: rtl/nmr_bstrm_fifo_wr.sv
// Producer end of the NMR pulse-program bitstream FIFO. Accepts pattern/duration
// entries, packs them into bitstream words (long holds split over several words)
// and writes them into the FIFO.
//  CLK, RST     : clock, asynchronous active-high reset
//  START        : 1-cycle arm pulse (ignored unless idle), clears ERR
//  STOP         : abort request level; forces a terminal all-zero word
//  ent (slave)  : entry handshake from the loader
//  fifo (master): FIFO write port
//  BUSY         : FSM not idle
//  DONE         : 1-cycle pulse the cycle after the final/terminal write
//  ERR          : sticky, zero-duration entry seen
module nmr_bstrm_fifo_wr
   import nmr_bstrm_pkg::*;
(
   input  logic               CLK,
   input  logic               RST,
   input  logic               START,
   input  logic               STOP,
   nmr_bstrm_entry_if.slave   ent,
   nmr_bstrm_fifo_if.master   fifo,
   output logic               BUSY,
   output logic               DONE,
   output logic               ERR
);

   state_t               state_q;
   logic [PAT_WIDTH-1:0] pat_q;
   logic                 last_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 err_q;

   logic                 accept_hs;
   logic                 wr_en;
   logic                 emit_wr;
   logic [CNT_WIDTH-1:0] chunk;
   logic                 final_chunk;

   // STOP masks both the handshake and the EMIT write so abort wins the cycle.
   assign ent.ready = (state_q == ST_ACCEPT) && !STOP;
   assign accept_hs = ent.valid && ent.ready;
   assign emit_wr   = (state_q == ST_EMIT) && !STOP && !fifo.full;
   assign wr_en     = emit_wr || ((state_q == ST_ABORT) && !fifo.full);

   assign fifo.wrreq = wr_en;
   // Word is derived from registers only, so it stays frozen while the FIFO is full.
   assign fifo.data  = (state_q == ST_EMIT)
                       ? pack_word(!final_chunk || !last_q, pat_q, chunk)
                       : TERM_WORD;

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign ERR  = err_q;

   nmr_bstrm_dur_split u_dur_split (
      .CLK     (CLK),
      .RST     (RST),
      .load_i  (accept_hs),
      .dur_i   (ent.dur),
      .step_i  (emit_wr),
      .chunk_o (chunk),
      .final_o (final_chunk)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         pat_q   <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (START) begin
                  state_q <= ST_ACCEPT;
                  busy_q  <= 1'b1;
                  err_q   <= 1'b0;
               end
            end
            ST_ACCEPT: begin
               if (STOP) begin
                  state_q <= ST_ABORT;
               end else if (accept_hs) begin
                  if (ent.dur == '0) begin
                     err_q <= 1'b1;
                  end else begin
                     pat_q   <= ent.pattern;
                     last_q  <= ent.last;
                     state_q <= ST_EMIT;
                  end
               end
            end
            ST_EMIT: begin
               if (STOP) begin
                  state_q <= ST_ABORT;
               end else if (emit_wr && final_chunk) begin
                  if (last_q) begin
                     state_q <= ST_FIN;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_ACCEPT;
                  end
               end
            end
            ST_ABORT: begin
               if (!fifo.full) begin
                  state_q <= ST_FIN;
                  done_q  <= 1'b1;
               end
            end
            ST_FIN: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nmr_bstrm_fifo_wr.sv
module tb_nmr_bstrm_fifo_wr;
   import nmr_bstrm_pkg::*;

   logic CLK = 1'b0;
   logic RST;
   logic START;
   logic STOP;
   logic BUSY;
   logic DONE;
   logic ERR;

   nmr_bstrm_entry_if ent ();
   nmr_bstrm_fifo_if  fifo ();

   nmr_bstrm_fifo_wr dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .STOP  (STOP),
      .ent   (ent),
      .fifo  (fifo),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .ERR   (ERR)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;
   int extra_wr = 0;
   int done_cnt = 0;
   int cycle = 0;
   int last_wr_cycle = -10;
   logic [BUS_WIDTH-1:0] sb[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(posedge CLK) cycle <= cycle + 1;

   // Scoreboard monitor: every write pops one expected word.
   always @(negedge CLK) begin
      if (!RST && fifo.wrreq === 1'b1) begin
         $display("WR cycle %0d data 0x%08h", cycle, fifo.data);
         if (sb.size() > 0) begin
            logic [BUS_WIDTH-1:0] exp_w;
            exp_w = sb.pop_front();
            check("wr_data", fifo.data, exp_w);
         end else begin
            extra_wr++;
         end
         last_wr_cycle = cycle;
      end
      if (!RST && DONE === 1'b1) begin
         done_cnt++;
         $display("DONE cycle %0d", cycle);
         check("done_lat", cycle, last_wr_cycle + 1);
      end
   end

   task automatic start_prog();
      @(posedge CLK); #1;
      START = 1'b1;
      @(posedge CLK); #1;
      START = 1'b0;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_entry(input logic [PAT_WIDTH-1:0] pat, input logic [DUR_WIDTH-1:0] dur,
                             input logic last);
      int n = 0;
      bit hs = 0;
      ent.pattern = pat;
      ent.dur     = dur;
      ent.last    = last;
      ent.valid   = 1'b1;
      while (!hs && n < 100) begin
         @(negedge CLK);
         if (ent.ready === 1'b1) hs = 1;
         else n++;
      end
      if (!hs) check("hs_timeout", 64'(hs), 64'd1);
      $display("ENTRY pat 0x%0h dur %0d last %0b accepted %0b", pat, dur, last, hs);
      @(posedge CLK); #1;
      ent.valid = 1'b0;
   endtask

   task automatic wait_done();
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < 300) begin
         @(posedge CLK);
         n++;
      end
      @(negedge CLK);
      check("busy_fall", 64'(BUSY), 64'd0);
      @(posedge CLK); #1;
      check("done_once", 64'(done_cnt - d0), 64'd1);
      check("sb_empty", 64'(sb.size()), 64'd0);
      check("extra_wr", 64'(extra_wr), 64'd0);
   endtask

   initial begin
      RST = 1'b1;
      START = 1'b0;
      STOP = 1'b0;
      ent.valid = 1'b0;
      ent.pattern = '0;
      ent.dur = '0;
      ent.last = 1'b0;
      fifo.full = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("rst_ready", 64'(ent.ready), 64'd0);
      check("rst_wrreq", 64'(fifo.wrreq), 64'd0);
      check("rst_data", 64'(fifo.data), 64'd0);
      check("rst_busy", 64'(BUSY), 64'd0);
      check("rst_done", 64'(DONE), 64'd0);
      check("rst_err", 64'(ERR), 64'd0);
      @(posedge CLK); #1;
      RST = 1'b0;

      // 1: single short entry
      start_prog();
      check("t1_busy", 64'(BUSY), 64'd1);
      sb.push_back(32'h0500_0009);
      send_entry(7'h05, 32'd10, 1'b1);
      wait_done();

      // 2: two entries, first has MORE set
      start_prog();
      sb.push_back(32'h8100_0002);
      sb.push_back(32'h0200_0003);
      send_entry(7'h01, 32'd3, 1'b0);
      send_entry(7'h02, 32'd4, 1'b1);
      wait_done();

      // 3: duration above one chunk splits into two words
      start_prog();
      sb.push_back(32'hFFFF_FFFF);
      sb.push_back(32'h7F00_0004);
      send_entry(7'h7F, (32'd1 << 24) + 32'd5, 1'b1);
      wait_done();

      // 4: FIFO full stalls EMIT with a frozen word
      start_prog();
      fifo.full = 1'b1;
      sb.push_back(32'h0300_0063);
      send_entry(7'h03, 32'd100, 1'b1);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         check("t4_wrreq_full", 64'(fifo.wrreq), 64'd0);
         check("t4_data_hold", 64'(fifo.data), 64'h0300_0063);
      end
      @(posedge CLK); #1;
      fifo.full = 1'b0;
      @(negedge CLK);
      check("t4_wr_release", 64'(fifo.wrreq), 64'd1);
      wait_done();

      // 5: STOP beats a same-cycle entry, terminal word written
      start_prog();
      ent.pattern = 7'h2A;
      ent.dur = 32'd7;
      ent.last = 1'b1;
      ent.valid = 1'b1;
      STOP = 1'b1;
      @(negedge CLK);
      check("t5_ready_stop", 64'(ent.ready), 64'd0);
      check("t5_wrreq_stop", 64'(fifo.wrreq), 64'd0);
      sb.push_back(TERM_WORD);
      @(posedge CLK); #1;
      STOP = 1'b0;
      ent.valid = 1'b0;
      wait_done();

      // 6: zero-duration entry flags ERR; reset during EMIT clears everything
      start_prog();
      send_entry(7'h11, 32'd0, 1'b0);
      @(negedge CLK);
      check("t6_err", 64'(ERR), 64'd1);
      check("t6_ready", 64'(ent.ready), 64'd1);
      @(posedge CLK); #1;
      fifo.full = 1'b1;
      send_entry(7'h01, 32'd50, 1'b1);
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check("t6_err_sticky", 64'(ERR), 64'd1);
      check("t6_emit_data", 64'(fifo.data), 64'h0100_0031);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(negedge CLK);
      check("t6_rst_busy", 64'(BUSY), 64'd0);
      check("t6_rst_done", 64'(DONE), 64'd0);
      check("t6_rst_err", 64'(ERR), 64'd0);
      check("t6_rst_wrreq", 64'(fifo.wrreq), 64'd0);
      check("t6_rst_data", 64'(fifo.data), 64'd0);
      check("t6_rst_ready", 64'(ent.ready), 64'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      fifo.full = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      check("t6_no_wr", 64'(extra_wr), 64'd0);
      check("t6_sb_empty", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
